// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the two-channel TDM demultiplexer.
package tdm_pkg;

    typedef enum logic {
        StHunt,
        StRun
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned frame_len(int unsigned width);
        return 2 * width;
    endfunction

    // Width of the frame position counter, never narrower than one bit.
    function automatic int unsigned pos_width(int unsigned width);
        int unsigned w;
        w = $clog2(frame_len(width));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tdm_demux2_if.sv
// Serial-in / dual-parallel-out bundle of the TDM demultiplexer.
interface tdm_demux2_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             d_in;
    logic             frame;
    logic [WIDTH-1:0] d1_out;
    logic [WIDTH-1:0] d2_out;
    logic             d1_valid;
    logic             d2_valid;
    logic             sel_out;
    logic             locked;
    logic             sync_err;

    modport master (
        output d_in, frame,
        input  d1_out, d2_out, d1_valid, d2_valid, sel_out, locked, sync_err
    );

    modport slave (
        input  d_in, frame,
        output d1_out, d2_out, d1_valid, d2_valid, sel_out, locked, sync_err
    );

endinterface

// File: rtl/tdm_shift_capture.sv
// MSB-first shift register whose completed word is captured into a held
// output register together with a one-cycle valid pulse.
module tdm_shift_capture #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             capture,
    output logic [WIDTH-1:0] word,
    output logic             valid
);

    logic [WIDTH-1:0] shifted;

    // Only WIDTH-1 bits of history are needed: the bit being sampled completes the word.
    if (WIDTH == 1) begin : g_single
        assign shifted = bit_in;
    end else begin : g_shift
        logic [WIDTH-2:0] sr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr_q <= '0;
            end else if (shift_en) begin
                sr_q <= shifted[WIDTH-2:0];
            end
        end

        assign shifted = {sr_q, bit_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                word <= shifted;
            end
        end
    end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: frame tracking FSM and position counter,
// with one shift/capture unit per channel.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux2_if.slave  bus
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned PW        = pos_width(WIDTH);
    localparam logic [PW-1:0] POS_C1   = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);

    state_e          state_q;
    logic [PW-1:0]   pos_q;
    logic [PW-1:0]   pos_eff;
    logic [PW-1:0]   pos_next;
    logic            accept;
    logic            start;
    logic            err;
    logic            cap1;
    logic            cap2;
    logic            sel_q;
    logic            locked_q;
    logic            err_q;

    // In RUN, pos_q == 0 only at the expected start of the next frame.
    always_comb begin
        accept = 1'b0;
        start  = 1'b0;
        err    = 1'b0;
        if (state_q == StHunt) begin
            accept = bus.frame;
            start  = bus.frame;
        end else if (pos_q == '0) begin
            accept = bus.frame;
            start  = bus.frame;
            err    = !bus.frame;
        end else begin
            accept = 1'b1;
            start  = bus.frame;
            err    = bus.frame;
        end
        pos_eff  = start ? '0 : pos_q;
        pos_next = '0;
        if (accept && (pos_eff != POS_LAST)) begin
            pos_next = pos_eff + 1'b1;
        end
        cap1 = accept && (pos_eff == POS_C1);
        cap2 = accept && (pos_eff == POS_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StHunt;
            pos_q    <= '0;
            sel_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= err;
            pos_q    <= pos_next;
            // Next bit belongs to channel 2 exactly when the next position is past channel 1.
            sel_q    <= pos_next > POS_C1;
            state_q  <= accept ? StRun : StHunt;
            locked_q <= accept;
        end
    end

    tdm_shift_capture #(.WIDTH(WIDTH)) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .bit_in   (bus.d_in),
        .capture  (cap1),
        .word     (bus.d1_out),
        .valid    (bus.d1_valid)
    );

    tdm_shift_capture #(.WIDTH(WIDTH)) u_ch2 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .bit_in   (bus.d_in),
        .capture  (cap2),
        .word     (bus.d2_out),
        .valid    (bus.d2_valid)
    );

    assign bus.sel_out  = sel_q;
    assign bus.locked   = locked_q;
    assign bus.sync_err = err_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Bench for tdm_demux2 at WIDTH=8 and WIDTH=1, checked every cycle against a
// queue-based frame model.
module tb_tdm_demux2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;

    always #5 clk = ~clk;

    tdm_demux2_if #(.WIDTH(8)) bus8 ();
    tdm_demux2_if #(.WIDTH(1)) bus1 ();

    tdm_demux2 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    tdm_demux2 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Model state, index 0 = WIDTH 8, index 1 = WIDTH 1.
    int         wd[2] = '{8, 1};
    int         n[2];
    bit         hunt[2];
    bit         q[2][$];
    logic [7:0] e1[2], e2[2];
    bit         v1[2], v2[2], es[2], sel[2], lk[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hunt[k] = 1'b1;
            n[k]    = 0;
            q[k].delete();
            e1[k] = '0; e2[k] = '0;
            v1[k] = 0; v2[k] = 0; es[k] = 0; sel[k] = 0; lk[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit f, bit d);
        bit         take;
        logic [7:0] word;
        take = 0; v1[k] = 0; v2[k] = 0; es[k] = 0;
        if (hunt[k]) begin
            take = f;
        end else if (n[k] == 2 * wd[k]) begin
            take = f;
            if (!f) begin
                es[k]   = 1;
                hunt[k] = 1;
            end
        end else begin
            take  = 1;
            es[k] = f;
        end
        if (take && f) begin
            n[k] = 0;
            q[k].delete();
        end
        if (take) begin
            hunt[k] = 0;
            q[k].push_back(d);
            n[k]++;
            if (q[k].size() == wd[k]) begin
                word = '0;
                foreach (q[k][i]) word = {word[6:0], q[k][i]};
                if (n[k] == wd[k]) begin
                    e1[k] = word; v1[k] = 1;
                end else begin
                    e2[k] = word; v2[k] = 1;
                end
                q[k].delete();
            end
        end
        sel[k] = take && (n[k] >= wd[k]) && (n[k] < 2 * wd[k]);
        lk[k]  = !hunt[k];
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("w8 d1_out",   bus8.d1_out,   e1[0]);
        chk("w8 d2_out",   bus8.d2_out,   e2[0]);
        chk("w8 d1_valid", {7'b0, bus8.d1_valid}, {7'b0, v1[0]});
        chk("w8 d2_valid", {7'b0, bus8.d2_valid}, {7'b0, v2[0]});
        chk("w8 sel_out",  {7'b0, bus8.sel_out},  {7'b0, sel[0]});
        chk("w8 locked",   {7'b0, bus8.locked},   {7'b0, lk[0]});
        chk("w8 sync_err", {7'b0, bus8.sync_err}, {7'b0, es[0]});
        chk("w1 d1_out",   {7'b0, bus1.d1_out},   e1[1]);
        chk("w1 d2_out",   {7'b0, bus1.d2_out},   e2[1]);
        chk("w1 d1_valid", {7'b0, bus1.d1_valid}, {7'b0, v1[1]});
        chk("w1 d2_valid", {7'b0, bus1.d2_valid}, {7'b0, v2[1]});
        chk("w1 sel_out",  {7'b0, bus1.sel_out},  {7'b0, sel[1]});
        chk("w1 locked",   {7'b0, bus1.locked},   {7'b0, lk[1]});
        chk("w1 sync_err", {7'b0, bus1.sync_err}, {7'b0, es[1]});
    endtask

    task automatic cyc(bit f8, bit d8, bit f1, bit d1);
        bus8.frame = f8; bus8.d_in = d8;
        bus1.frame = f1; bus1.d_in = d1;
        @(posedge clk);
        model_step(0, f8, d8);
        model_step(1, f1, d1);
        #1;
        check_all();
    endtask

    // WIDTH=1 lane runs a fixed "frame every 2 cycles, bits 1 then 0" pattern.
    task automatic step8(bit f, bit d);
        bit even;
        even = (ph % 2) == 0;
        ph++;
        cyc(f, d, even, even);
    endtask

    task automatic send_byte(bit first, logic [7:0] b);
        for (int i = 7; i >= 0; i--) step8(first && (i == 7), b[i]);
    endtask

    initial begin
        bus8.frame = 0; bus8.d_in = 0;
        bus1.frame = 0; bus1.d_in = 0;
        model_reset();
        #12;
        check_all();
        #5 rst = 1'b0;

        // Single clean frame, then a back-to-back frame.
        send_byte(1, 8'hA5);
        send_byte(0, 8'h3C);
        send_byte(1, 8'h0F);
        send_byte(0, 8'hF0);
        // Missing frame pulse: loss of lock, outputs held.
        for (int i = 0; i < 4; i++) step8(0, 1'($urandom));
        chk("held d1 after loss", bus8.d1_out, 8'h0F);
        chk("held d2 after loss", bus8.d2_out, 8'hF0);

        // Resync in the middle of channel 1.
        step8(1, 1'b1);
        for (int i = 0; i < 4; i++) step8(0, 1'($urandom));
        send_byte(1, 8'h81);
        send_byte(0, 8'h42);
        chk("resync d1", bus8.d1_out, 8'h81);

        // Asynchronous reset twelve bits into a frame.
        send_byte(1, 8'h5A);
        for (int i = 0; i < 4; i++) step8(0, 1'($urandom));
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        bus8.frame = 0; bus1.frame = 0;
        @(negedge clk);
        rst = 1'b0;
        send_byte(1, 8'hC3);
        send_byte(0, 8'h96);
        chk("post-reset d1", bus8.d1_out, 8'hC3);
        chk("post-reset d2", bus8.d2_out, 8'h96);

        // Mostly well-framed random traffic with occasional dropped or stray pulses.
        for (int c = 0; c < 600; c++) begin
            bit f8, f1;
            int r;
            r  = int'($urandom_range(0, 63));
            f8 = ((c % 16) == 0) ? (r > 6) : (r == 0);
            r  = int'($urandom_range(0, 15));
            f1 = ((c % 2) == 0) ? (r > 1) : (r == 0);
            cyc(f8, 1'($urandom), f1, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 select mux.
- Takes a serial bit stream d_in framed by a one-cycle frame pulse.
- Splits each frame into a channel-1 word and a channel-2 word, MSB first.
- Presents each word on a held parallel output with a one-cycle valid strobe.
- Sits between a serial link front end and the per-channel consumer logic.

Parameters:
WIDTH, 8, bits per channel word (legal range >= 1); frame length is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
d_in  input  1  serial data, sampled every rising clk edge
frame  input  1  high on the cycle d_in carries bit 0 of a frame (channel-1 MSB)
d1_out  output  WIDTH  last complete channel-1 word, held until next capture
d2_out  output  WIDTH  last complete channel-2 word, held until next capture
d1_valid  output  1  one-cycle pulse: d1_out just updated
d2_valid  output  1  one-cycle pulse: d2_out just updated
sel_out  output  1  registered; 0 while channel-1 bits or HUNT, 1 while channel-2 bits
locked  output  1  high while the frame position is tracked (not HUNT)
sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (asynchronous assert, synchronous release by clk): state HUNT, pos=0, shift register=0.
  - All outputs are 0: d1_out, d2_out, d1_valid, d2_valid, sel_out, locked, sync_err.
  - A reset mid-frame discards the partial word. d1_out/d2_out clear to 0.
- States: HUNT, RUN. pos is a frame position counter, 0..2*WIDTH-1, width max(1, $clog2(2*WIDTH)).
- HUNT: frame=0 means d_in is ignored. frame=1 means this bit is pos 0: shift it in and enter RUN (locked=1 from the next cycle).
- RUN: each cycle shift d_in into the shift register (MSB first) and advance pos.
  - The bit at pos WIDTH-1 completes channel 1. Next cycle: d1_out = word, d1_valid=1.
  - The bit at pos 2*WIDTH-1 completes channel 2. Next cycle: d2_out = word, d2_valid=1.
  - Capture latency: exactly 1 cycle after the last bit's sampling edge.
- Expected frame position: the cycle after pos 2*WIDTH-1 was sampled.
  - frame=1 there: clean back-to-back frame, treat as pos 0, no error.
  - frame=0 there: sync_err=1, go HUNT, locked=0 next cycle, bit ignored.
- frame=1 at any other RUN position: sync_err=1, discard the partial word, and treat the bit as pos 0 of a new frame (stay RUN).
  - An unfinished word never produces a valid.
  - Already-captured outputs stay held.
- Resync and capture on the same cycle: if frame=1 arrives on the cycle after a capture bit, the capture still completes (valid pulses). The frame bit starts the new frame.
- sel_out=1 exactly for the cycles following samples at pos WIDTH-1 .. 2*WIDTH-2, i.e. mirrors which channel the next bit belongs to.
- WIDTH=1: pos 0 completes channel 1 and pos 1 completes channel 2. The same rules apply.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package tdm_pkg:
  - state enum (HUNT, RUN)
  - localparam FRAME_LEN = 2*WIDTH
  - position counter width function
- One sub-module, tdm_shift_capture: WIDTH-bit shift register with capture-enable into a held output register and valid pulse. Instantiated once per channel, or shared with a select.
- The FSM and pos counter live in the top module.

Test Plan:
- WIDTH=8, frame on edge 0, bits A5 then 3C -> d1_out=0xA5 and d1_valid at cycle 8; d2_out=0x3C and d2_valid at cycle 16; sync_err never asserted.
- Back-to-back frames (A5,3C),(0F,F0), frame on edges 0 and 16 -> four valid pulses at cycles 8,16,24,32 with matching words; locked stays 1 throughout.
- Frame on edge 0, then no frame at edge 16 -> sync_err at cycle 17, locked=0 from 17. d1_out/d2_out keep 0xA5/0x3C. No further valids until the next frame.
- Frame at edges 0 and 5 (mid channel 1), then bits 0x81 -> sync_err at cycle 6. No d1_valid at 8. d1_out=0x81 and d1_valid at cycle 13.
- rst asserted asynchronously (between clk edges) at cycle 12 of a frame -> all outputs 0 immediately, state HUNT. The next frame decodes cleanly with no sync_err.
- WIDTH=1, frame every 2 cycles with bits 1,0 -> d1_out=1 and d2_out=0 alternately valid each cycle; sel_out toggles each cycle.
